// File: rtl/conv_accumulator_if.sv
// Product-in and result-out handshakes of the convolution accumulator.
// master: producer/consumer side; slave: the accumulator itself.
interface conv_accumulator_if #(
    parameter int ACC_W = 20
);
    logic [15:0]      product;
    logic             product_valid;
    logic             in_ready;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic             out_ready;

    modport master (
        output product, product_valid, out_ready,
        input  in_ready, sum, sum_valid
    );

    modport slave (
        input  product, product_valid, out_ready,
        output in_ready, sum, sum_valid
    );
endinterface

// File: rtl/conv_accumulator.sv
// Kernel-window accumulator behind the 8x8 multiplier: sums TAPS accepted
// products and presents each window result on a valid/ready register.
// The window keeps filling while a result waits, so windows run back to back.
//
// state   | meaning
// --------+------------------------------------------------
// S_EMPTY | output register holds no untaken result
// S_FULL  | sum holds a result waiting for out_ready
module conv_accumulator #(
    parameter int TAPS  = 9,
    parameter int ACC_W = 20
) (
    input  logic                clock,
    input  logic                reset_n,
    conv_accumulator_if.slave   bus,
    input  logic                clear,
    output logic [7:0]          tap_count,
    output logic                busy
);

    localparam logic [7:0] LAST_TAP = 8'(TAPS - 1);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_plus;
    logic [ACC_W-1:0] sum_r;
    logic             last_tap;
    logic             accept;
    logic             complete;

    // Only the window-completing product can stall, and only when the held
    // result is not leaving this cycle.
    always_comb begin
        last_tap    = (tap_count == LAST_TAP);
        bus.in_ready = !((state == S_FULL) && !bus.out_ready && last_tap);
        accept      = bus.product_valid && bus.in_ready && !clear;
        complete    = accept && last_tap;
        acc_plus    = acc + ACC_W'(bus.product);
    end

    // Partial sum and tap counter; clear beats any product in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            tap_count <= '0;
        end else if (clear || complete) begin
            acc       <= '0;
            tap_count <= '0;
        end else if (accept) begin
            acc       <= acc_plus;
            tap_count <= tap_count + 8'd1;
        end
    end

    // Result register: loads only on completion, otherwise holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum_r <= '0;
        end else if (complete) begin
            sum_r <= acc_plus;
        end
    end

    // Output FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output FSM next state: a completion always leaves the register full,
    // even when the previous result is popped in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (complete) state_nxt = S_FULL;
            S_FULL:  if (bus.out_ready && !complete) state_nxt = S_EMPTY;
            default: state_nxt = S_EMPTY;
        endcase
    end

    assign bus.sum       = sum_r;
    assign bus.sum_valid = (state == S_FULL);
    assign busy          = (tap_count != 8'd0);

endmodule

// File: tb/tb_conv_accumulator.sv
// Testbench for conv_accumulator: table-driven basic window, directed corner
// sequences, and randomized traffic against a window-list reference model.
module tb_conv_accumulator;

    localparam int TAPS  = 9;
    localparam int ACC_W = 20;

    logic       clock;
    logic       reset_n;
    logic       clear;
    logic [7:0] tap_count;
    logic       busy;

    conv_accumulator_if #(.ACC_W(ACC_W)) bus ();

    conv_accumulator #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .clear     (clear),
        .tap_count (tap_count),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: products of the open window, plus the result register.
    int unsigned      win[$];
    bit               m_full;
    logic [ACC_W-1:0] m_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_full = 1'b0;
        m_sum  = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".sum"},       32'(bus.sum),       32'(m_sum));
        chk({tag, ".sum_valid"}, 32'(bus.sum_valid), 32'(m_full));
        chk({tag, ".tap_count"}, 32'(tap_count),     32'(win.size()));
        chk({tag, ".busy"},      32'(busy),          32'(win.size() != 0));
    endtask

    // Apply one cycle of inputs, check in_ready before the edge, advance the
    // model across the edge, then check the registered outputs.
    task automatic step(input bit pv, input logic [15:0] p, input bit clr,
                        input bit ordy, output bit rdy_seen);
        bit          exp_rdy;
        bit          acc_ok;
        bit          done;
        longint      s;
        bus.product_valid = pv;
        bus.product       = p;
        clear             = clr;
        bus.out_ready     = ordy;
        #1;
        exp_rdy  = !(m_full && !ordy && (win.size() == TAPS - 1));
        rdy_seen = bus.in_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        @(posedge clock);
        #1;
        acc_ok = pv && exp_rdy && !clr;
        done   = 1'b0;
        if (clr) begin
            win.delete();
        end else if (acc_ok) begin
            win.push_back(int'(p));
            if (win.size() == TAPS) begin
                s = 0;
                foreach (win[k]) s += longint'(win[k]);
                m_sum = ACC_W'(s);
                done  = 1'b1;
                win.delete();
            end
        end
        if (done) m_full = 1'b1;
        else if (m_full && ordy) m_full = 1'b0;
        check_outputs("model");
    endtask

    typedef struct {
        bit               pv;
        logic [15:0]      p;
        bit               clr;
        bit               ordy;
        logic [ACC_W-1:0] e_sum;
        bit               e_valid;
        logic [7:0]       e_tap;
        bit               e_ready;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        bit r;

        for (int i = 0; i < 9; i++)
            tbl[i] = '{pv: 1'b1, p: 16'(i + 1), clr: 1'b0, ordy: 1'b1,
                       e_sum: (i == 8) ? ACC_W'(45) : '0, e_valid: (i == 8),
                       e_tap: 8'((i + 1) % 9), e_ready: 1'b1};
        tbl[9] = '{pv: 1'b0, p: 16'h0, clr: 1'b0, ordy: 1'b1,
                   e_sum: ACC_W'(45), e_valid: 1'b0, e_tap: 8'd0, e_ready: 1'b1};

        reset_n           = 1'b0;
        clear             = 1'b0;
        bus.product       = '0;
        bus.product_valid = 1'b0;
        bus.out_ready     = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst.sum",       32'(bus.sum),       32'd0);
        chk("rst.sum_valid", 32'(bus.sum_valid), 32'd0);
        chk("rst.tap_count", 32'(tap_count),     32'd0);
        chk("rst.busy",      32'(busy),          32'd0);
        chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
        reset_n = 1'b1;

        // Basic window, table-driven.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].pv, tbl[i].p, tbl[i].clr, tbl[i].ordy, r);
            chk("tbl.in_ready",  32'(r),             32'(tbl[i].e_ready));
            chk("tbl.sum",       32'(bus.sum),       32'(tbl[i].e_sum));
            chk("tbl.sum_valid", 32'(bus.sum_valid), 32'(tbl[i].e_valid));
            chk("tbl.tap_count", 32'(tap_count),     32'(tbl[i].e_tap));
        end

        // Max value: nine 0xFFFF products fit without wrapping.
        for (int i = 0; i < 9; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b1, r);
        chk("max.sum",   32'(bus.sum),       32'h8FFF7);
        chk("max.valid", 32'(bus.sum_valid), 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b1, r);

        // Back-to-back windows with backpressure, then pop with completion.
        for (int i = 0; i < 9; i++) step(1'b1, 16'd1, 1'b0, 1'b0, r);
        chk("bp.sum1", 32'(bus.sum), 32'd9);
        for (int i = 0; i < 8; i++) step(1'b1, 16'd2, 1'b0, 1'b0, r);
        chk("bp.hold_sum", 32'(bus.sum), 32'd9);
        chk("bp.tap8",     32'(tap_count), 32'd8);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'd2, 1'b0, 1'b0, r);
            chk("bp.stall_ready", 32'(r),             32'd0);
            chk("bp.stall_sum",   32'(bus.sum),       32'd9);
            chk("bp.stall_valid", 32'(bus.sum_valid), 32'd1);
        end
        step(1'b1, 16'd2, 1'b0, 1'b1, r);
        chk("pop.ready", 32'(r),             32'd1);
        chk("pop.sum",   32'(bus.sum),       32'd18);
        chk("pop.valid", 32'(bus.sum_valid), 32'd1);
        chk("pop.tap",   32'(tap_count),     32'd0);
        step(1'b0, 16'h0, 1'b0, 1'b1, r);
        chk("pop.drain", 32'(bus.sum_valid), 32'd0);

        // clear mid-window drops the coincident product.
        for (int i = 0; i < 4; i++) step(1'b1, 16'd10, 1'b0, 1'b1, r);
        step(1'b1, 16'd10, 1'b1, 1'b1, r);
        chk("clr.tap",  32'(tap_count), 32'd0);
        chk("clr.busy", 32'(busy),      32'd0);
        for (int i = 0; i < 9; i++) step(1'b1, 16'd3, 1'b0, 1'b1, r);
        chk("clr.sum",   32'(bus.sum),       32'd27);
        chk("clr.valid", 32'(bus.sum_valid), 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b1, r);

        // Asynchronous reset with a held result and a part-filled window.
        for (int i = 0; i < 14; i++) step(1'b1, 16'd1, 1'b0, 1'b0, r);
        chk("ar.pre_tap",   32'(tap_count),     32'd5);
        chk("ar.pre_valid", 32'(bus.sum_valid), 32'd1);
        bus.product_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar.sum",      32'(bus.sum),       32'd0);
        chk("ar.valid",    32'(bus.sum_valid), 32'd0);
        chk("ar.tap",      32'(tap_count),     32'd0);
        chk("ar.busy",     32'(busy),          32'd0);
        chk("ar.in_ready", 32'(bus.in_ready),  32'd1);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b1, 16'd1, 1'b0, 1'b1, r);
        chk("ar.post_sum",   32'(bus.sum),       32'd9);
        chk("ar.post_valid", 32'(bus.sum_valid), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          pv;
            bit          clr;
            bit          ordy;
            logic [15:0] p;
            pv   = ($urandom_range(0, 9) < 8);
            clr  = ($urandom_range(0, 39) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            p    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            step(pv, p, clr, ordy, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_accumulator.md
# conv_accumulator

Downstream stage of the 8x8 Wallace-tree multiplier in the convolution datapath. Consumes the registered 16-bit unsigned products one per cycle and sums TAPS consecutive accepted products into one kernel-window result. Presents each result on a valid/ready output register. The window counter keeps running while a result waits to be taken, so back-to-back windows run at full rate.

## Interface
- TAPS, 9: products per kernel window; legal range 2..256.
- ACC_W, 20: accumulator and result width; must be ≥ 16 + ceil(log2(TAPS)).
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- product  in  16  unsigned product from the multiplier.
- product_valid  in  1  `product` is valid this cycle.
- in_ready  out  1  stage accepts `product` this cycle; combinational.
- clear  in  1  synchronous abort of the window in progress.
- sum  out  ACC_W  completed window sum; registered.
- sum_valid  out  1  `sum` holds an untaken result.
- out_ready  in  1  consumer takes `sum` this cycle.
- tap_count  out  8  number of products accepted in the current window.
- busy  out  1  high when tap_count ≠ 0.

## Operation
- **Accept:** a product is accepted when `product_valid && in_ready && !clear`. On accept, `acc <= acc + product` (zero-extended) and `tap_count` increments.
- **Window complete:** on the accept where `tap_count == TAPS-1`:
  - `sum <= acc + product`
  - `sum_valid <= 1`
  - `acc <= 0`
  - `tap_count <= 0`
- **Backpressure:**
  - `in_ready = !(sum_valid && !out_ready && tap_count == TAPS-1)`.
  - A completing product is refused only while the output register is occupied and not being taken that cycle.
  - Non-completing products are always accepted.
- **Output register FSM, two states:**
  - EMPTY (`sum_valid=0`): a completion moves it to FULL.
  - FULL (`sum_valid=1`): `out_ready` with no completion → EMPTY. `out_ready` with a simultaneous completion → stays FULL and `sum` is replaced by the new result. No `out_ready` → hold `sum` stable.
- **clear:**
  - Zeroes `acc` and `tap_count` next cycle.
  - A product presented in the same cycle is dropped; clear wins.
  - Does not touch `sum` or `sum_valid`; the output handshake proceeds normally during clear.
- **Arithmetic:** unsigned; wraps modulo 2^ACC_W. With legal parameters no overflow is possible.
- **Reset (any time, including mid-window or with a result held):** all state discarded. In-flight partial sums are lost with no output.

## Timing
- Reset values:
  - `sum` = 0
  - `sum_valid` = 0
  - `tap_count` = 0
  - `busy` = 0
  - `acc` = 0
  - `in_ready` = 1 (combinational)
- Throughput: one product per cycle. One result every TAPS cycles under continuous valid/ready.
- Latency: `sum_valid` rises on the clock edge that accepts the TAPS-th product. The result is visible the cycle after that product is presented.
- Output handshake completes on the edge where `sum_valid && out_ready`.
- `sum` must not change while `sum_valid=1` and `out_ready=0`.
- `in_ready` depends combinationally on `out_ready`; the consumer must not derive `out_ready` from `in_ready`.
- Upstream pairing: the controller asserts `product_valid` one cycle after presenting x/y, matching the multiplier's single-register latency. This block does not track that alignment.

## Test plan
- **Basic window:** TAPS=9, products 1..9 on consecutive cycles, `out_ready=1` → `sum=45`, `sum_valid` high for exactly one cycle after the 9th accept; `tap_count` back to 0.
- **Max value:** nine products of 0xFFFF → `sum=0x8FFF7` (589815); no wrap.
- **Back-to-back with backpressure:**
  - Stimulus: two windows (all 1s, then all 2s) streamed continuously; `out_ready=0` until 5 cycles after the second window's 8th product.
  - Required: first window shows `sum=9` held stable; `in_ready` low on the 9th product of window 2; after `out_ready` rises, 9 is taken, then `sum=18`.
- **Simultaneous pop and completion:** `sum=9` held; 9th product of the next window arrives in the same cycle as `out_ready=1` → `sum` becomes 18 with `sum_valid` never dropping.
- **clear mid-window:**
  - Stimulus: after 4 products of 10, assert `clear` together with a valid product 10, then feed 9 products of 3.
  - Required: `sum=27`; the dropped product is not counted.
- **Reset mid-operation:** `reset_n` low asynchronously with `tap_count=5` and `sum_valid=1` → all outputs at reset values immediately; next 9 products of 1 give `sum=9`.
